// File: rtl/mem_arbiter.sv
// Purpose: shares one main-memory line port between I-cache fills and D-cache fills/write-backs.
// Latency: grant edge -> mem_req_o next cycle; mem_resp_i -> requester resp pulse next cycle.
// Backpressure: requesters hold req until their resp pulse; one transaction in flight at a time.
module mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int LINE_W    = 128,
    parameter int MEM_BYTES = 32768,
    parameter int TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    // I-cache line fill port
    input  logic              ic_req_i,
    input  logic [ADDR_W-1:0] ic_addr_i,
    output logic              ic_resp_o,
    output logic [LINE_W-1:0] ic_rdata_o,
    output logic              ic_err_o,
    // D-cache fill / write-back port
    input  logic              dc_req_i,
    input  logic              dc_we_i,
    input  logic [ADDR_W-1:0] dc_addr_i,
    input  logic [LINE_W-1:0] dc_wdata_i,
    output logic              dc_resp_o,
    output logic [LINE_W-1:0] dc_rdata_o,
    output logic              dc_err_o,
    // main-memory line port
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic              mem_resp_i,
    input  logic [LINE_W-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int                CNT_W      = $clog2(TIMEOUT + 1);
    // Last WAIT cycle: counter value TIMEOUT-1 means TIMEOUT cycles already spent waiting.
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_BYTES);
    localparam logic              OWN_IC     = 1'b0;
    localparam logic              OWN_DC     = 1'b1;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;      // requester owning the in-flight transaction
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_dc_q, last_dc_d;  // 1 = most recent grant went to the D-cache
    logic [LINE_W-1:0] ic_rdata_q, ic_rdata_d;
    logic              ic_err_q, ic_err_d;
    logic [LINE_W-1:0] dc_rdata_q, dc_rdata_d;
    logic              dc_err_q, dc_err_d;

    // Grant decision and result-load helpers (combinational).
    logic              grant_dc;
    logic [ADDR_W-1:0] grant_addr;
    logic              load_en;
    logic              load_owner;
    logic [LINE_W-1:0] load_rdata;
    logic              load_err;

    // State and datapath registers; reset puts everything idle with last grant = I-cache.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IC;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            last_dc_q  <= 1'b0;
            ic_rdata_q <= '0;
            ic_err_q   <= 1'b0;
            dc_rdata_q <= '0;
            dc_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            last_dc_q  <= last_dc_d;
            ic_rdata_q <= ic_rdata_d;
            ic_err_q   <= ic_err_d;
            dc_rdata_q <= dc_rdata_d;
            dc_err_q   <= dc_err_d;
        end
    end

    // Next-state logic: arbitration in IDLE, range check, response/timeout handling in WAIT.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        last_dc_d  = last_dc_q;
        ic_rdata_d = ic_rdata_q;
        ic_err_d   = ic_err_q;
        dc_rdata_d = dc_rdata_q;
        dc_err_d   = dc_err_q;
        load_en    = 1'b0;
        load_owner = owner_q;
        load_rdata = '0;
        load_err   = 1'b0;

        // On a tie the D-cache wins unless it was the last one served.
        grant_dc         = dc_req_i && (!ic_req_i || !last_dc_q);
        grant_addr       = grant_dc ? dc_addr_i : ic_addr_i;
        grant_addr[3:0]  = 4'h0;

        case (state_q)
            IDLE: begin
                if (ic_req_i || dc_req_i) begin
                    owner_d   = grant_dc;
                    last_dc_d = grant_dc;
                    we_d      = grant_dc & dc_we_i;
                    addr_d    = grant_addr;
                    wdata_d   = grant_dc ? dc_wdata_i : '0;
                    cnt_d     = '0;
                    if (grant_addr >= ADDR_LIMIT) begin
                        // Out-of-range: answer with an error without touching memory.
                        state_d    = RESP;
                        load_en    = 1'b1;
                        load_owner = grant_dc;
                        load_err   = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                // A response arriving in the final wait cycle still counts as success.
                if (mem_resp_i) begin
                    state_d    = RESP;
                    load_en    = 1'b1;
                    load_rdata = we_q ? '0 : mem_rdata_i;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = RESP;
                    load_en  = 1'b1;
                    load_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Result registers of the owning port change only when entering RESP, so they
        // hold their value until that port's next response.
        if (load_en) begin
            if (load_owner == OWN_DC) begin
                dc_rdata_d = load_rdata;
                dc_err_d   = load_err;
            end else begin
                ic_rdata_d = load_rdata;
                ic_err_d   = load_err;
            end
        end
    end

    assign mem_req_o   = (state_q == ISSUE);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

    assign ic_resp_o   = (state_q == RESP) && (owner_q == OWN_IC);
    assign dc_resp_o   = (state_q == RESP) && (owner_q == OWN_DC);
    assign ic_rdata_o  = ic_rdata_q;
    assign ic_err_o    = ic_err_q;
    assign dc_rdata_o  = dc_rdata_q;
    assign dc_err_o    = dc_err_q;

endmodule
